// File: rtl/lc3b_types.sv
// Shared LC-3b data types and byte-lane enable encodings for the data-memory path.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  function automatic lc3b_word align_word(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/dmem_byte_steer.sv
// Combinational LC-3b byte-lane steering: lane enables, store-data replication and
// zero-extended byte-load extraction for one data-memory access.
module dmem_byte_steer
  import lc3b_types::*;
(
  input  logic       addr_lsb,
  input  logic       is_byte,
  input  logic       is_write,
  input  lc3b_word   wdata,
  input  lc3b_word   mem_rdata,
  output logic [1:0] byte_enable,
  output lc3b_word   mem_wdata,
  output lc3b_word   load_data
);

  // Byte loads read the whole word and pick a lane; byte stores replicate into both lanes.
  always_comb begin
    byte_enable = BE_WORD;
    mem_wdata   = wdata;
    load_data   = mem_rdata;
    if (is_byte) begin
      load_data = {8'h00, (addr_lsb ? mem_rdata[15:8] : mem_rdata[7:0])};
      if (is_write) begin
        byte_enable = addr_lsb ? BE_HI : BE_LO;
        mem_wdata   = {wdata[7:0], wdata[7:0]};
      end else begin
        byte_enable = BE_WORD;
        mem_wdata   = wdata;
      end
    end else begin
      byte_enable = BE_WORD;
      mem_wdata   = wdata;
      load_data   = mem_rdata;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory port controller: runs one handshaked access per memory-stage request,
// steers byte lanes and stalls the pipeline until the access completes.
module dmem_access_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic                 req_byte,
  input  logic [15:0]          req_addr,
  input  logic [15:0]          req_wdata,
  output logic                 stall,
  output logic [15:0]          rdata,
  output logic                 rdata_valid,
  output logic [CNT_WIDTH-1:0] access_count,
  output logic                 dmem_read,
  output logic                 dmem_write,
  output logic [1:0]           dmem_byte_enable,
  output logic [15:0]          dmem_address,
  output logic [15:0]          dmem_wdata,
  input  logic [15:0]          dmem_rdata,
  input  logic                 dmem_resp
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  lc3b_word             addr_q, addr_d;
  lc3b_word             wdata_q, wdata_d;
  lc3b_word             rdata_q, rdata_d;
  logic                 byte_q, byte_d;
  logic                 write_q, write_d;
  logic [CNT_WIDTH-1:0] access_count_q, access_count_d;

  logic [1:0]           steer_be;
  lc3b_word             steer_wdata;
  lc3b_word             steer_load;

  dmem_byte_steer u_steer (
    .addr_lsb    (addr_q[0]),
    .is_byte     (byte_q),
    .is_write    (write_q),
    .wdata       (wdata_q),
    .mem_rdata   (dmem_rdata),
    .byte_enable (steer_be),
    .mem_wdata   (steer_wdata),
    .load_data   (steer_load)
  );

  // State and request-latch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      addr_q         <= 16'h0000;
      wdata_q        <= 16'h0000;
      rdata_q        <= 16'h0000;
      byte_q         <= 1'b0;
      write_q        <= 1'b0;
      access_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
      byte_q         <= byte_d;
      write_q        <= write_d;
      access_count_q <= access_count_d;
    end
  end

  // Next-state logic; a simultaneous read and write request is treated as a write.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    byte_d         = byte_q;
    write_d        = write_q;
    access_count_d = access_count_q;
    case (state_q)
      S_IDLE: begin
        if (req_read || req_write) begin
          state_d = S_ACCESS;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          byte_d  = req_byte;
          write_d = req_write;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (dmem_resp) begin
          state_d = S_DONE;
          rdata_d = write_q ? rdata_q : steer_load;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_DONE: begin
        state_d        = S_IDLE;
        access_count_d = access_count_q + CNT_ONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus strobes come only from registered state; stall also covers the request cycle.
  always_comb begin
    stall            = 1'b0;
    rdata_valid      = 1'b0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_byte_enable = BE_NONE;
    dmem_address     = 16'h0000;
    dmem_wdata       = 16'h0000;
    case (state_q)
      S_IDLE: begin
        stall = req_read | req_write;
      end
      S_ACCESS: begin
        stall            = 1'b1;
        dmem_read        = ~write_q;
        dmem_write       = write_q;
        dmem_byte_enable = steer_be;
        dmem_address     = align_word(addr_q);
        dmem_wdata       = write_q ? steer_wdata : 16'h0000;
      end
      S_DONE: begin
        rdata_valid = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign rdata        = rdata_q;
  assign access_count = access_count_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized self-checking bench for dmem_access_ctrl against a transaction-level model.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_read = 1'b0, req_write = 1'b0, req_byte = 1'b0;
  logic [15:0] req_addr = 16'h0000, req_wdata = 16'h0000;
  logic [15:0] dmem_rdata = 16'h0000;
  logic        dmem_resp = 1'b0;

  logic        stall, rdata_valid, dmem_read, dmem_write;
  logic [15:0] rdata, access_count, dmem_address, dmem_wdata;
  logic [1:0]  dmem_byte_enable;

  logic        stall4, rdata_valid4, dmem_read4, dmem_write4;
  logic [15:0] rdata4, dmem_address4, dmem_wdata4;
  logic [3:0]  access_count4;
  logic [1:0]  dmem_byte_enable4;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .access_count(access_count),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  dmem_access_ctrl #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall4), .rdata(rdata4), .rdata_valid(rdata_valid4), .access_count(access_count4),
    .dmem_read(dmem_read4), .dmem_write(dmem_write4), .dmem_byte_enable(dmem_byte_enable4),
    .dmem_address(dmem_address4), .dmem_wdata(dmem_wdata4),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Transaction-level reference: an outstanding access, then a one-cycle completion.
  bit          m_busy = 1'b0, m_done = 1'b0, m_wr = 1'b0, m_byte = 1'b0;
  logic [15:0] m_addr = 16'h0000, m_wd = 16'h0000, m_rdata = 16'h0000, m_count = 16'h0000;

  function automatic logic [15:0] exp_load(input bit byt, input logic [15:0] a, input logic [15:0] r);
    if (byt) return (r >> (8 * a[0])) & 16'h00FF;
    return r;
  endfunction

  function automatic logic [1:0] exp_be(input bit wr, input bit byt, input logic [15:0] a);
    logic [1:0] one;
    one = 2'b01;
    if (wr && byt) return one << a[0];
    return 2'b11;
  endfunction

  function automatic logic [15:0] exp_wdata(input bit byt, input logic [15:0] w);
    if (byt) return {8'h00, w[7:0]} * 16'h0101;
    return w;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_rdata <= 16'h0000; m_count <= 16'h0000;
    end else if (m_done) begin
      m_done  <= 1'b0;
      m_count <= m_count + 16'h0001;
    end else if (m_busy) begin
      if (dmem_resp) begin
        if (!m_wr) m_rdata <= exp_load(m_byte, m_addr, dmem_rdata);
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end
    end else if (req_read || req_write) begin
      m_busy <= 1'b1; m_wr <= req_write; m_byte <= req_byte;
      m_addr <= req_addr; m_wd <= req_wdata;
    end
  end

  task automatic cmp_outputs(input string tag, input logic s, input logic [15:0] rd, input logic v,
                             input logic r, input logic w, input logic [1:0] be,
                             input logic [15:0] ad, input logic [15:0] wd);
    check({tag, "stall"}, 32'(s), 32'(m_busy || (!m_done && (req_read || req_write))));
    check({tag, "rdata"}, 32'(rd), 32'(m_rdata));
    check({tag, "rdata_valid"}, 32'(v), 32'(m_done));
    check({tag, "dmem_read"}, 32'(r), 32'(m_busy && !m_wr));
    check({tag, "dmem_write"}, 32'(w), 32'(m_busy && m_wr));
    check({tag, "byte_enable"}, 32'(be), m_busy ? 32'(exp_be(m_wr, m_byte, m_addr)) : 32'h0);
    check({tag, "address"}, 32'(ad), m_busy ? 32'({m_addr[15:1], 1'b0}) : 32'h0);
    check({tag, "wdata"}, 32'(wd), (m_busy && m_wr) ? 32'(exp_wdata(m_byte, m_wd)) : 32'h0);
  endtask

  // Observation counters for the directed scenarios, sampled mid-cycle.
  int          obs_stall = 0, obs_valid = 0, obs_rd = 0, obs_wr = 0;
  logic [15:0] obs_addr = 16'h0000, obs_wdata = 16'h0000;
  logic [1:0]  obs_be = 2'b00;

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_outputs("", stall, rdata, rdata_valid, dmem_read, dmem_write, dmem_byte_enable,
                  dmem_address, dmem_wdata);
      check("count", 32'(access_count), 32'(m_count));
      cmp_outputs("w4_", stall4, rdata4, rdata_valid4, dmem_read4, dmem_write4, dmem_byte_enable4,
                  dmem_address4, dmem_wdata4);
      check("w4_count", 32'(access_count4), 32'(m_count[3:0]));
    end
    if (stall) obs_stall <= obs_stall + 1;
    if (rdata_valid) obs_valid <= obs_valid + 1;
    if (dmem_read) begin
      obs_rd <= obs_rd + 1; obs_addr <= dmem_address; obs_be <= dmem_byte_enable;
    end
    if (dmem_write) begin
      obs_wr <= obs_wr + 1; obs_addr <= dmem_address; obs_be <= dmem_byte_enable;
      obs_wdata <= dmem_wdata;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access: request in cycle 0, response in cycle k, then the completion cycle.
  task automatic do_access(input bit rd, input bit wr, input bit byt, input logic [15:0] addr,
                           input logic [15:0] wd, input int k, input logic [15:0] rdat,
                           input bit noise);
    req_read = rd; req_write = wr; req_byte = byt; req_addr = addr; req_wdata = wd;
    dmem_resp = 1'b0;
    next_cycle();
    for (int i = 1; i < k; i++) begin
      dmem_rdata = 16'($urandom);
      next_cycle();
    end
    dmem_resp = 1'b1; dmem_rdata = rdat;
    next_cycle();
    dmem_rdata = 16'($urandom);
    if (noise) begin
      req_read = 1'($urandom); req_write = 1'($urandom); dmem_resp = 1'($urandom);
      req_addr = 16'($urandom);
    end else begin
      req_read = 1'b0; req_write = 1'b0; dmem_resp = 1'b0;
    end
    next_cycle();
    req_read = 1'b0; req_write = 1'b0; dmem_resp = 1'b0;
  endtask

  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      req_read = 1'b0; req_write = 1'b0;
      dmem_resp = noise ? 1'($urandom) : 1'b0;
      dmem_rdata = 16'($urandom);
      next_cycle();
    end
    dmem_resp = 1'b0;
  endtask

  int s0, v0, r0, w0;

  task automatic snap();
    s0 = obs_stall; v0 = obs_valid; r0 = obs_rd; w0 = obs_wr;
  endtask

  initial begin
    next_cycle();
    chk_en = 1'b1;
    next_cycle();
    reset = 1'b0;

    check("rst_stall", 32'(stall), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_valid", 32'(rdata_valid), 32'h0);
    check("rst_count", 32'(access_count), 32'h0);
    check("rst_read", 32'(dmem_read), 32'h0);
    check("rst_write", 32'(dmem_write), 32'h0);
    check("rst_be", 32'(dmem_byte_enable), 32'h0);
    check("rst_addr", 32'(dmem_address), 32'h0);
    check("rst_wdata", 32'(dmem_wdata), 32'h0);

    // Spurious response while idle.
    snap();
    dmem_resp = 1'b1; dmem_rdata = 16'hFFFF;
    next_cycle();
    dmem_resp = 1'b0;
    next_cycle();
    check("spur_rdata", 32'(rdata), 32'h0);
    check("spur_count", 32'(access_count), 32'h0);
    check("spur_valid_pulses", 32'(obs_valid - v0), 32'h0);
    check("spur_read", 32'(obs_rd - r0), 32'h0);

    // Word load, response after 3 cycles.
    snap();
    do_access(1'b1, 1'b0, 1'b0, 16'h1235, 16'h0000, 3, 16'hBEEF, 1'b0);
    check("ldw_stall_cycles", 32'(obs_stall - s0), 32'd4);
    check("ldw_valid_pulses", 32'(obs_valid - v0), 32'd1);
    check("ldw_read_cycles", 32'(obs_rd - r0), 32'd3);
    check("ldw_addr", 32'(obs_addr), 32'h1234);
    check("ldw_be", 32'(obs_be), 32'h3);
    check("ldw_rdata", 32'(rdata), 32'hBEEF);
    check("ldw_count", 32'(access_count), 32'd1);

    // Byte store to the high lane.
    snap();
    do_access(1'b0, 1'b1, 1'b1, 16'h2001, 16'h00A5, 2, 16'h1111, 1'b0);
    check("stb_wdata", 32'(obs_wdata), 32'hA5A5);
    check("stb_be", 32'(obs_be), 32'h2);
    check("stb_addr", 32'(obs_addr), 32'h2000);
    check("stb_write_cycles", 32'(obs_wr - w0), 32'd2);
    check("stb_read_cycles", 32'(obs_rd - r0), 32'd0);
    check("stb_rdata_kept", 32'(rdata), 32'hBEEF);
    check("stb_count", 32'(access_count), 32'd2);

    // Byte loads from both lanes.
    do_access(1'b1, 1'b0, 1'b1, 16'h2000, 16'h0000, 1, 16'h8C41, 1'b0);
    check("ldb_lo_rdata", 32'(rdata), 32'h0041);
    check("ldb_lo_be", 32'(obs_be), 32'h3);
    do_access(1'b1, 1'b0, 1'b1, 16'h2001, 16'h0000, 2, 16'h8C41, 1'b0);
    check("ldb_hi_rdata", 32'(rdata), 32'h008C);
    check("ldb_count", 32'(access_count), 32'd4);

    // Read and write together: the write wins.
    snap();
    do_access(1'b1, 1'b1, 1'b0, 16'h3000, 16'h1234, 2, 16'h5555, 1'b0);
    check("both_read_cycles", 32'(obs_rd - r0), 32'd0);
    check("both_write_cycles", 32'(obs_wr - w0), 32'd2);
    check("both_wdata", 32'(obs_wdata), 32'h1234);
    check("both_rdata_kept", 32'(rdata), 32'h008C);

    // Reset during an access, response arriving one cycle late.
    snap();
    req_read = 1'b1; req_byte = 1'b0; req_addr = 16'h4444;
    next_cycle();
    check("mid_read_active", 32'(dmem_read), 32'h1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; req_read = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'h7777;
    check("mid_read_dropped", 32'(dmem_read), 32'h0);
    next_cycle();
    dmem_resp = 1'b0;
    next_cycle();
    check("mid_valid_pulses", 32'(obs_valid - v0), 32'd0);
    check("mid_count", 32'(access_count), 32'h0);
    check("mid_rdata", 32'(rdata), 32'h0);

    // Counter wrap on the 4-bit instance.
    for (int i = 0; i < 15; i++) begin
      do_access(1'b1, 1'b0, 1'b0, 16'(i * 2), 16'h0000, 1, 16'($urandom), 1'b0);
    end
    check("wrap_before", 32'(access_count4), 32'hF);
    do_access(1'b0, 1'b1, 1'b0, 16'h0100, 16'hCAFE, 1, 16'h0000, 1'b0);
    check("wrap_after", 32'(access_count4), 32'h0);
    check("wrap_count16", 32'(access_count), 32'h10);

    // Randomized traffic with noise on ignored inputs.
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      do_access(kind != 1, kind == 1 || kind == 2, 1'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(1, 4), 16'($urandom), 1'b1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 1'b1);
    end
    idle(2, 1'b0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
